mem_bank: RTL and testbench
===========================

# mem_bank

Parametrised single-port synchronous RAM bank, the next generation of the CPU's word memory. It serves one requester over a valid/ready request channel with a fixed-latency response channel. Width, depth, base address and read latency are configurable. Out-of-range and misaligned accesses are flagged as errors instead of being silently ignored. It sits between the core's memory interface and on-chip EBR/SPRAM.

## Interface
- DATA_WIDTH, 32: word width in bits; a multiple of 8, power of two.
- DEPTH, 15872: number of words.
- BASE, 32'h0000_0000: byte address of word 0; must be aligned to DATA_WIDTH/8.
- LATENCY, 1: cycles from request acceptance to response; legal range 1..4.

Ports, all synchronous to `clk`:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  request present.
- mem_ready  out  1  bank can accept a request this cycle.
- mem_addr  in  32  byte address.
- mem_wdata  in  DATA_WIDTH  write data.
- mem_wstrb  in  DATA_WIDTH/8  byte write enables; all zero means read.
- mem_rvalid  out  1  one-cycle response pulse.
- mem_rdata  out  DATA_WIDTH  word contents before this request.
- mem_error  out  1  the request was out of range or misaligned; qualified by mem_rvalid.

## Operation
- Acceptance: a request is accepted when mem_valid && mem_ready. One request per cycle, fully pipelined.
- Decode:
  - BYTES = DATA_WIDTH/8 and offset = mem_addr - BASE.
  - The request is in range iff mem_addr >= BASE && offset < DEPTH*BYTES.
  - The word index is offset >> log2(BYTES).
  - The request is misaligned iff offset[log2(BYTES)-1:0] != 0.
- Good request:
  - Each byte lane whose strobe bit is set is written.
  - mem_rdata returns the word as it was before the write (read-first), for reads and writes alike.
  - The response doubles as the write acknowledge.
- Error request (out of range or misaligned):
  - RAM is unmodified.
  - The response carries mem_rdata = 0 and mem_error = 1.
- Response channel:
  - There is no backpressure; the requester must take every response.
  - Responses are returned in request order.
- Reset:
  - mem_rvalid, mem_error and mem_rdata become 0.
  - All in-flight responses are discarded.
  - RAM contents are retained unless MEM_BANK_CLEAR_EN is defined.
- mem_ready is 0 while reset is high.

## Timing
- A request accepted at edge N produces mem_rvalid high for exactly the cycle after edge N+LATENCY-1. With LATENCY=1, the response is visible in the cycle after acceptance.
- mem_rdata and mem_error hold their values between responses; only mem_rvalid qualifies them.
- Same-word write at N followed by read at N+1: the read returns the newly written data. There is no hazard window, because the array write completes at edge N.
- Without the clear feature, mem_ready is high in the first cycle after reset drops.

## Configuration
- Macro: MEM_BANK_CLEAR_EN.
- When defined, a two-state FSM controls the bank:
  - CLEAR:
    - Entered on reset, with the counter set to 0.
    - Each cycle writes 0 to word[counter] and increments the counter.
    - mem_ready is 0.
    - After writing word DEPTH-1, moves to RUN.
    - Clearing takes DEPTH cycles after reset drops.
  - RUN: normal operation with mem_ready = 1.
  - Reset asserted mid-CLEAR restarts the counter at 0.
  - The counter width is clog2(DEPTH).
- When undefined:
  - No FSM and no counter.
  - Contents are undefined at power-up and preserved across reset.

## Structure
- Package mem_pkg contains:
  - the mem_resp_t struct {rdata, error}, with the data width passed by parameterised typedef or fixed at 32 with a width-generic wrapper;
  - the mem_state_e enum {CLEAR, RUN};
  - a constant function computing log2 of the byte count.
- Sub-module mem_resp_pipe is a LATENCY-deep shift register of {valid, mem_resp_t}, reset to zero. It is used for the response path only; the array read is in the first stage.
- The top level holds the array, decode logic and the optional clear FSM.

## Test plan
- Write/read, DATA_WIDTH=32, BASE=0x100, LATENCY=1:
  - Write 0xDEADBEEF with wstrb 4'b1111 to 0x104, then read 0x104.
  - Required: the read returns 0xDEADBEEF one cycle after acceptance, with mem_error=0.
- Byte strobes:
  - Write 0x11223344 with wstrb 4'b0101 over a word holding 0xAABBCCDD.
  - Required: a following read returns 0xAA22CC44.
- Errors:
  - Read 0x0FC (below base), read BASE+4*DEPTH, and read 0x102 (misaligned).
  - Required: each response has mem_error=1 and mem_rdata=0, and the memory is unchanged.
- Latency:
  - Set LATENCY=3 and issue back-to-back reads of three addresses on consecutive cycles.
  - Required: three consecutive mem_rvalid pulses starting 3 cycles after the first acceptance, in order.
- Reset:
  - Assert reset with 2 responses in flight.
  - Required: no mem_rvalid after reset, and outputs read 0.
  - With MEM_BANK_CLEAR_EN and DEPTH=16, mem_ready stays low for 16 cycles and every word then reads 0.
  - Re-asserting reset at clear cycle 5 restarts the 16-cycle count.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the mem_bank slice: bank state, response record and decode helper.
package mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } mem_state_e;

  // Default-width response record; mem_resp_pipe builds the same layout at any DATA_WIDTH.
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } mem_resp_t;

  function automatic int mem_byte_log2(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mem_bank_if.sv
// Request/response bundle between a requester (master) and mem_bank (slave).
// A request transfers on a rising edge where mem_valid && mem_ready; its response comes back
// later as a one-cycle mem_rvalid pulse that cannot be stalled, in request order.
interface mem_bank_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    mem_valid;
  logic                    mem_ready;
  logic [31:0]             mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_error;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata, mem_error
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata, mem_error
  );
endinterface

// File: rtl/mem_resp_pipe.sv
// LATENCY-deep response shift register; stage 0 captures the array read at acceptance.
// The last stage only reloads data/error on a valid response so the outputs hold between pulses.
module mem_resp_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_error,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_error
);
  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  error;
  } stage_t;

  stage_t r_stage [LATENCY];
  stage_t w_src   [LATENCY];

  assign w_src[0] = '{valid: i_valid, rdata: i_rdata, error: i_error};

  for (genvar g = 1; g < LATENCY; g++) begin : g_src
    assign w_src[g] = r_stage[g-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY - 1; i++) r_stage[i] <= w_src[i];
      r_stage[LATENCY-1].valid <= w_src[LATENCY-1].valid;
      if (w_src[LATENCY-1].valid) begin
        r_stage[LATENCY-1].rdata <= w_src[LATENCY-1].rdata;
        r_stage[LATENCY-1].error <= w_src[LATENCY-1].error;
      end
    end
  end

  assign o_valid = r_stage[LATENCY-1].valid;
  assign o_rdata = r_stage[LATENCY-1].rdata;
  assign o_error = r_stage[LATENCY-1].error;

endmodule

// File: rtl/mem_bank.sv
// mem_bank: single-port read-first RAM bank with range/alignment checking and fixed-latency responses.
// Define MEM_BANK_CLEAR_EN to zero the whole array after every reset before requests are accepted.
module mem_bank
  import mem_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 15872,
  parameter logic [31:0] BASE       = 32'h0000_0000,
  parameter int          LATENCY    = 1
) (
  input  logic       clk,
  input  logic       reset,
  mem_bank_if.slave  bus,
  output mem_state_e o_dbg_state
);
  localparam int          BYTES = DATA_WIDTH / 8;
  localparam int          LB    = mem_byte_log2(DATA_WIDTH);
  localparam int          IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'(BYTES);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [31:0]           w_offset;
  logic [IW-1:0]         w_idx;
  logic                  w_in_range;
  logic                  w_misalign;
  logic                  w_err;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_clr_we;
  logic [IW-1:0]         w_clr_idx;

  assign w_offset   = bus.mem_addr - BASE;
  assign w_in_range = (bus.mem_addr >= BASE) && ({32'd0, w_offset} < SPAN);
  assign w_misalign = (w_offset & 32'(BYTES - 1)) != 32'd0;
  assign w_err      = !w_in_range || w_misalign;
  assign w_idx      = IW'(w_offset >> LB);
  assign w_accept   = bus.mem_valid && bus.mem_ready;
  // Read-first: the response captures the word before this edge's write lands.
  assign w_rdata    = w_err ? '0 : r_mem[w_idx];

`ifdef MEM_BANK_CLEAR_EN
  mem_state_e    r_state;
  mem_state_e    w_state_next;
  logic [IW-1:0] r_cnt;
  logic [IW-1:0] w_cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_clr_we     = 1'b0;
    if (r_state == CLEAR && !reset) begin
      w_clr_we = 1'b1;
      if (r_cnt == IW'(DEPTH - 1)) begin
        w_state_next = RUN;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  assign w_clr_idx     = r_cnt;
  assign bus.mem_ready = !reset && (r_state == RUN);
  assign o_dbg_state   = r_state;
`else
  assign w_clr_we      = 1'b0;
  assign w_clr_idx     = '0;
  assign bus.mem_ready = !reset;
  assign o_dbg_state   = RUN;
`endif

  // The array has no reset: contents survive reset unless the clear sweep overwrites them.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_accept && !w_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.mem_wstrb[b]) r_mem[w_idx][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end
    end
  end

  mem_resp_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (LATENCY)
  ) u_resp_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_accept),
    .i_rdata (w_rdata),
    .i_error (w_err),
    .o_valid (bus.mem_rvalid),
    .o_rdata (bus.mem_rdata),
    .o_error (bus.mem_error)
  );

endmodule

// File: tb/tb_mem_bank.sv
// Bench for mem_bank: two banks (LATENCY 1 and 3, DEPTH 16, BASE 0x100) driven from a vector
// table and hand sequences, with a per-bank expected-response queue checked on every mem_rvalid.
module tb_mem_bank;
  import mem_pkg::*;

  localparam int          DW    = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h100;

  logic       clk;
  logic       reset;
  mem_state_e st0;
  mem_state_e st1;

  mem_bank_if #(.DATA_WIDTH(DW)) if0 ();
  mem_bank_if #(.DATA_WIDTH(DW)) if1 ();

  mem_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0), .o_dbg_state(st0)
  );
  mem_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE(BASE), .LATENCY(3)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1), .o_dbg_state(st1)
  );

  // ---------------- clock / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errs   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk;
    int          due;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t e0;
  exp_t e1;

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (if0.mem_rvalid) begin
        if (exp_q0.size() == 0) begin
          check("d0_unexpected_rvalid", 32'(if0.mem_rvalid), 32'd0);
        end else begin
          e0 = exp_q0.pop_front();
          check("d0_resp_cycle", 32'(cyc), 32'(e0.due));
          check("d0_error", 32'(if0.mem_error), 32'(e0.err));
          if (e0.chk) check("d0_rdata", if0.mem_rdata, e0.rdata);
        end
      end else if (exp_q0.size() != 0 && exp_q0[0].due <= cyc) begin
        check("d0_missing_rvalid", 32'(if0.mem_rvalid), 32'd1);
        void'(exp_q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (if1.mem_rvalid) begin
        if (exp_q1.size() == 0) begin
          check("d1_unexpected_rvalid", 32'(if1.mem_rvalid), 32'd0);
        end else begin
          e1 = exp_q1.pop_front();
          check("d1_resp_cycle", 32'(cyc), 32'(e1.due));
          check("d1_error", 32'(if1.mem_error), 32'(e1.err));
          if (e1.chk) check("d1_rdata", if1.mem_rdata, e1.rdata);
        end
      end else if (exp_q1.size() != 0 && exp_q1[0].due <= cyc) begin
        check("d1_missing_rvalid", 32'(if1.mem_rvalid), 32'd1);
        void'(exp_q1.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  // Called just after a falling edge; the request is accepted at the next rising edge.
  task automatic drive0(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic chk, input logic err, input logic [31:0] rdata);
    int n;
    n = 0;
    while (!if0.mem_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!if0.mem_ready) begin
      check("d0_ready_timeout", 32'(if0.mem_ready), 32'd1);
      return;
    end
    if0.mem_valid = 1'b1;
    if0.mem_addr  = addr;
    if0.mem_wdata = wdata;
    if0.mem_wstrb = wstrb;
    exp_q0.push_back('{rdata: rdata, err: err, chk: chk, due: cyc + 1});
    @(negedge clk);
    if0.mem_valid = 1'b0;
  endtask

  task automatic drive1(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic chk, input logic err, input logic [31:0] rdata);
    int n;
    n = 0;
    while (!if1.mem_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!if1.mem_ready) begin
      check("d1_ready_timeout", 32'(if1.mem_ready), 32'd1);
      return;
    end
    if1.mem_valid = 1'b1;
    if1.mem_addr  = addr;
    if1.mem_wdata = wdata;
    if1.mem_wstrb = wstrb;
    exp_q1.push_back('{rdata: rdata, err: err, chk: chk, due: cyc + 3});
    @(negedge clk);
    if1.mem_valid = 1'b0;
  endtask

  task automatic count_clear(output int n);
    n = 0;
    #1;
    while (!if0.mem_ready && n < 64) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int          n;
    logic [31:0] ret_exp;

    vecs[0]  = '{32'h104,      32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{32'h104,      32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{32'h108,      32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{32'h108,      32'h11223344, 4'h5, 1'b1, 1'b0, 32'hAABBCCDD};
    vecs[4]  = '{32'h108,      32'h0,        4'h0, 1'b1, 1'b0, 32'hAA22CC44};
    vecs[5]  = '{32'h0FC,      32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{32'h140,      32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{32'h102,      32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
    vecs[8]  = '{32'h106,      32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'h0};
    vecs[9]  = '{32'h104,      32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[10] = '{32'h13C,      32'h12345678, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{32'h13C,      32'h0,        4'h0, 1'b1, 1'b0, 32'h12345678};
    vecs[12] = '{32'h104,      32'h00000055, 4'h1, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[13] = '{32'h104,      32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBE55};
    vecs[14] = '{32'hFFFFFFFC, 32'h99999999, 4'hF, 1'b1, 1'b1, 32'h0};
    vecs[15] = '{32'h13C,      32'h0,        4'h0, 1'b1, 1'b0, 32'h12345678};

    reset = 1'b1;
    if0.mem_valid = 1'b0; if0.mem_addr = '0; if0.mem_wdata = '0; if0.mem_wstrb = '0;
    if1.mem_valid = 1'b0; if1.mem_addr = '0; if1.mem_wdata = '0; if1.mem_wstrb = '0;
    repeat (3) @(negedge clk);

    check("rst_rvalid0", 32'(if0.mem_rvalid), 32'd0);
    check("rst_error0",  32'(if0.mem_error),  32'd0);
    check("rst_rdata0",  if0.mem_rdata,       32'd0);
    check("rst_rvalid1", 32'(if1.mem_rvalid), 32'd0);
    check("rst_error1",  32'(if1.mem_error),  32'd0);
    check("rst_rdata1",  if1.mem_rdata,       32'd0);
    check("rst_ready0",  32'(if0.mem_ready),  32'd0);
    check("rst_ready1",  32'(if1.mem_ready),  32'd0);

    reset = 1'b0;
`ifdef MEM_BANK_CLEAR_EN
    count_clear(n);
    check("clear_cycles", 32'(n), 32'd16);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("clear_ready_low_mid", 32'(if0.mem_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_clear(n);
    check("clear_restart_cycles", 32'(n), 32'd16);
    for (int i = 0; i < DEPTH; i++) drive0(BASE + 32'(4 * i), 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    ret_exp = 32'h0;
`else
    #1;
    check("ready0_after_reset", 32'(if0.mem_ready), 32'd1);
    check("ready1_after_reset", 32'(if1.mem_ready), 32'd1);
    ret_exp = 32'h12345678;
`endif

    // Table on the LATENCY=1 bank, with occasional idle gaps between groups of four.
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      drive0(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].chk, vecs[i].err, vecs[i].rdata);
    end
    repeat (3) @(negedge clk);
    check("d0_hold_rdata",  if0.mem_rdata,       32'h12345678);
    check("d0_hold_rvalid", 32'(if0.mem_rvalid), 32'd0);

    // LATENCY=3: back-to-back reads must return as three consecutive pulses in order.
    drive1(32'h100, 32'hA1A1A1A1, 4'hF, 1'b0, 1'b0, 32'h0);
    drive1(32'h110, 32'hB2B2B2B2, 4'hF, 1'b0, 1'b0, 32'h0);
    drive1(32'h120, 32'hC3C3C3C3, 4'hF, 1'b0, 1'b0, 32'h0);
    drive1(32'h100, 32'h0, 4'h0, 1'b1, 1'b0, 32'hA1A1A1A1);
    drive1(32'h110, 32'h0, 4'h0, 1'b1, 1'b0, 32'hB2B2B2B2);
    drive1(32'h120, 32'h0, 4'h0, 1'b1, 1'b0, 32'hC3C3C3C3);
    repeat (5) @(negedge clk);
    check("d1_hold_rdata", if1.mem_rdata, 32'hC3C3C3C3);

    // Reset with two responses in flight on the LATENCY=3 bank.
    drive1(32'h100, 32'h0, 4'h0, 1'b1, 1'b0, 32'hA1A1A1A1);
    drive1(32'h110, 32'h0, 4'h0, 1'b1, 1'b0, 32'hB2B2B2B2);
    reset = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(negedge clk);
    check("inflight_rst_rvalid1", 32'(if1.mem_rvalid), 32'd0);
    check("inflight_rst_rdata1",  if1.mem_rdata,       32'd0);
    check("inflight_rst_error1",  32'(if1.mem_error),  32'd0);
    check("inflight_rst_ready1",  32'(if1.mem_ready),  32'd0);
    check("inflight_rst_rdata0",  if0.mem_rdata,       32'd0);
    reset = 1'b0;
`ifndef MEM_BANK_CLEAR_EN
    #1;
    check("ready1_after_rst2", 32'(if1.mem_ready), 32'd1);
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_rvalid1", 32'(if1.mem_rvalid), 32'd0);
    end

    // Contents across reset: retained by default, zeroed by the clear sweep.
    drive0(32'h13C, 32'h0, 4'h0, 1'b1, 1'b0, ret_exp);

    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
